// File: rtl/dma_csr_bank.sv
// AXI4-Lite CSR bank: global page plus NUM_CH per-channel DMA descriptor/status pages.
// Latency: B response and ch_start one cycle after AW+W are both held; R data one cycle after AR.
// Backpressure: one write and one read in flight; AW/W/AR stall while B/R wait for bready/rready.
module dma_csr_bank #(
    parameter int          NUM_CH     = 4,
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          LEN_WIDTH  = 24,
    parameter logic [31:0] ID_VALUE   = 32'hD3A0_0100
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       s_axil_awaddr,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [DATA_WIDTH-1:0]       s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]     s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]       s_axil_araddr,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [DATA_WIDTH-1:0]       s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,
    output logic [NUM_CH-1:0]           ch_start,
    output logic [NUM_CH*32-1:0]        ch_src,
    output logic [NUM_CH*32-1:0]        ch_dst,
    output logic [NUM_CH*LEN_WIDTH-1:0] ch_len,
    input  logic [NUM_CH-1:0]           ch_busy,
    input  logic [NUM_CH-1:0]           ch_done,
    input  logic [NUM_CH-1:0]           ch_err,
    output logic                        irq
);

    // Parameter sanity: refuse to elaborate configurations the register map cannot describe.
    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("dma_csr_bank: DATA_WIDTH must be 32");
        end
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
            $error("dma_csr_bank: NUM_CH must be in 1..8");
        end
        if (LEN_WIDTH < 1 || LEN_WIDTH > 32) begin : g_bad_len_width
            $error("dma_csr_bank: LEN_WIDTH must be in 1..32");
        end
        if (ADDR_WIDTH < 10) begin : g_bad_addr_width
            $error("dma_csr_bank: ADDR_WIDTH must be at least 10");
        end
    endgenerate

    localparam logic [1:0] GLB_ID      = 2'd0;
    localparam logic [1:0] GLB_IRQ     = 2'd1;
    localparam logic [1:0] GLB_SCRATCH = 2'd2;
    localparam logic [1:0] GLB_NUMCH   = 2'd3;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_SRC     = 3'd2;
    localparam logic [2:0] REG_DST     = 3'd3;
    localparam logic [2:0] REG_LEN     = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Decoded view of a word address (address bits [9:2]).
    typedef struct packed {
        logic       glb;      // hits the global page 0x000..0x00C
        logic       chn;      // hits an implemented channel register
        logic [1:0] glb_reg;
        logic [2:0] ch;
        logic [2:0] ch_reg;
    } dec_t;

    function automatic dec_t decode(input logic [7:0] word);
        dec_t d;
        d.glb     = (word[7:2] == 6'd0);
        d.chn     = (word[7:6] == 2'b01) && (int'(word[5:3]) < NUM_CH) && (word[2:0] <= REG_LEN);
        d.glb_reg = word[1:0];
        d.ch      = word[5:3];
        d.ch_reg  = word[2:0];
        return d;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] dat,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? dat[8*b +: 8] : cur[8*b +: 8];
        end
        return r;
    endfunction

    // Address bits outside [9:2] never influence decode.
    logic unused_addr;
    generate
        if (ADDR_WIDTH > 10) begin : g_unused_hi
            assign unused_addr = ^{s_axil_awaddr[ADDR_WIDTH-1:10], s_axil_awaddr[1:0],
                                   s_axil_araddr[ADDR_WIDTH-1:10], s_axil_araddr[1:0]};
        end else begin : g_unused_lo
            assign unused_addr = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
        end
    endgenerate

    // ---------------------------------------------------------------- state
    logic        aw_full;
    logic [7:0]  aw_word;
    logic        w_full;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    logic [31:0]          scratch;
    logic [NUM_CH-1:0]    irq_en;
    logic [NUM_CH-1:0]    st_done;
    logic [NUM_CH-1:0]    st_err;
    logic [NUM_CH-1:0]    st_drop;
    logic [31:0]          src_reg [NUM_CH];
    logic [31:0]          dst_reg [NUM_CH];
    logic [LEN_WIDTH-1:0] len_reg [NUM_CH];

    // ---------------------------------------------------------------- write path
    logic        aw_hs;
    logic        w_hs;
    logic        wr_fire;
    logic [7:0]  wr_word;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    dec_t        wdec;
    logic        wr_ok;

    assign s_axil_awready = !aw_full && !s_axil_bvalid;
    assign s_axil_wready  = !w_full && !s_axil_bvalid;
    assign aw_hs   = s_axil_awvalid && s_axil_awready;
    assign w_hs    = s_axil_wvalid && s_axil_wready;
    // A beat arriving this cycle completes the pair without waiting for the holding register.
    assign wr_fire = (aw_full || aw_hs) && (w_full || w_hs);
    assign wr_word = aw_full ? aw_word : s_axil_awaddr[9:2];
    assign wr_data = w_full ? w_data : s_axil_wdata;
    assign wr_strb = w_full ? w_strb : s_axil_wstrb;
    assign wdec    = decode(wr_word);
    assign wr_ok   = wdec.chn || (wdec.glb && wdec.glb_reg == GLB_SCRATCH);

    // Per-channel write strobes derived from the executing write.
    logic [NUM_CH-1:0]    ch_wr;
    logic [NUM_CH-1:0]    start_hit;
    logic [NUM_CH-1:0]    stat_wr;
    logic [LEN_WIDTH-1:0] len_new [NUM_CH];

    // Channel select, START/W1C qualification and the byte-merged LEN value.
    always_comb begin
        logic [31:0] len_wide;
        ch_wr     = '0;
        start_hit = '0;
        stat_wr   = '0;
        len_wide  = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            ch_wr[n]     = wr_fire && wr_ok && wdec.chn && (int'(wdec.ch) == n);
            start_hit[n] = ch_wr[n] && (wdec.ch_reg == REG_CTRL) && wr_strb[0] && wr_data[0];
            stat_wr[n]   = ch_wr[n] && (wdec.ch_reg == REG_STATUS) && wr_strb[0];
            len_wide     = merge_bytes(32'(len_reg[n]), wr_data, wr_strb);
            len_new[n]   = len_wide[LEN_WIDTH-1:0];
        end
    end

    // AW/W holding registers and the B channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full       <= 1'b0;
            aw_word       <= '0;
            w_full        <= 1'b0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
        end else begin
            if (wr_fire) begin
                aw_full       <= 1'b0;
                w_full        <= 1'b0;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_word <= s_axil_awaddr[9:2];
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_data <= s_axil_wdata;
                    w_strb <= s_axil_wstrb;
                end
                if (s_axil_bvalid && s_axil_bready) begin
                    s_axil_bvalid <= 1'b0;
                end
            end
        end
    end

    // Global SCRATCH register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch <= '0;
        end else if (wr_fire && wr_ok && wdec.glb) begin
            scratch <= merge_bytes(scratch, wr_data, wr_strb);
        end
    end

    // Channel descriptors, control, sticky status (set wins over clear) and start pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en   <= '0;
            st_done  <= '0;
            st_err   <= '0;
            st_drop  <= '0;
            ch_start <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                src_reg[n] <= '0;
                dst_reg[n] <= '0;
                len_reg[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_wr[n]) begin
                    case (wdec.ch_reg)
                        REG_CTRL: if (wr_strb[0]) irq_en[n] <= wr_data[1];
                        REG_SRC:  src_reg[n] <= merge_bytes(src_reg[n], wr_data, wr_strb);
                        REG_DST:  dst_reg[n] <= merge_bytes(dst_reg[n], wr_data, wr_strb);
                        REG_LEN:  len_reg[n] <= len_new[n];
                        default:  ;
                    endcase
                end
                st_done[n]  <= (st_done[n] && !(stat_wr[n] && wr_data[1])) || ch_done[n];
                st_err[n]   <= (st_err[n]  && !(stat_wr[n] && wr_data[2])) || ch_err[n];
                st_drop[n]  <= (st_drop[n] && !(stat_wr[n] && wr_data[3])) ||
                               (start_hit[n] && ch_busy[n]);
                ch_start[n] <= start_hit[n] && !ch_busy[n];
            end
        end
    end

    // ---------------------------------------------------------------- interrupt
    logic [NUM_CH-1:0] pending;
    assign pending = irq_en & (st_done | st_err);

    // Registered level interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |pending;
        end
    end

    // ---------------------------------------------------------------- read path
    dec_t        rdec;
    logic [31:0] rd_val;
    logic        rd_ok;

    assign s_axil_arready = !s_axil_rvalid;
    assign rdec = decode(s_axil_araddr[9:2]);

    // Read mux over current register contents; undecoded addresses return zero.
    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        if (rdec.glb) begin
            rd_ok = 1'b1;
            case (rdec.glb_reg)
                GLB_ID:      rd_val = ID_VALUE;
                GLB_IRQ:     rd_val = 32'(pending);
                GLB_SCRATCH: rd_val = scratch;
                GLB_NUMCH:   rd_val = 32'(NUM_CH);
                default:     rd_val = '0;
            endcase
        end else if (rdec.chn) begin
            rd_ok = 1'b1;
            for (int n = 0; n < NUM_CH; n++) begin
                if (int'(rdec.ch) == n) begin
                    case (rdec.ch_reg)
                        REG_CTRL:   rd_val = {30'd0, irq_en[n], 1'b0};
                        REG_STATUS: rd_val = {28'd0, st_drop[n], st_err[n], st_done[n], ch_busy[n]};
                        REG_SRC:    rd_val = src_reg[n];
                        REG_DST:    rd_val = dst_reg[n];
                        REG_LEN:    rd_val = 32'(len_reg[n]);
                        default:    rd_val = '0;
                    endcase
                end
            end
        end
    end

    // R channel: capture on AR handshake, hold until rready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_OKAY;
        end else if (s_axil_arvalid && s_axil_arready) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_val;
            s_axil_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil_rvalid && s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- engine-facing buses
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
            assign ch_src[32*g +: 32]               = src_reg[g];
            assign ch_dst[32*g +: 32]               = dst_reg[g];
            assign ch_len[LEN_WIDTH*g +: LEN_WIDTH] = len_reg[g];
        end
    endgenerate

endmodule

// File: tb/tb_dma_csr_bank.sv
// Directed bench for dma_csr_bank: register map, handshakes, W1C/interrupt behaviour and reset.
// Inputs change 1 ns after the rising edge and outputs are sampled at the same point.
// All expected values are hand-derived constants.
module tb_dma_csr_bank;
    localparam int NUM_CH    = 4;
    localparam int LEN_WIDTH = 24;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [NUM_CH-1:0]           ch_start;
    logic [NUM_CH*32-1:0]        ch_src;
    logic [NUM_CH*32-1:0]        ch_dst;
    logic [NUM_CH*LEN_WIDTH-1:0] ch_len;
    logic [NUM_CH-1:0]           ch_busy;
    logic [NUM_CH-1:0]           ch_done;
    logic [NUM_CH-1:0]           ch_err;
    logic                        irq;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt0 = 0;
    int start_cnt1 = 0;

    dma_csr_bank #(.NUM_CH(NUM_CH), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                   .LEN_WIDTH(LEN_WIDTH), .ID_VALUE(32'hD3A0_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .ch_start(ch_start), .ch_src(ch_src), .ch_dst(ch_dst), .ch_len(ch_len),
        .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err), .irq(irq)
    );

    always #5 clk = ~clk;

    // Count start pulses seen on each clock edge.
    always @(posedge clk) begin
        start_cnt0 <= start_cnt0 + int'(ch_start[0]);
        start_cnt1 <= start_cnt1 + int'(ch_start[1]);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [1:0] resp, output int lat);
        int  cyc;
        logic aw_hs, w_hs;
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
        cyc = 0;
        while ((awvalid || wvalid) && cyc < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            cyc++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 50) begin
            step();
            lat++;
        end
        resp = bresp;
        step();
    endtask

    task automatic axil_read(input logic [31:0] addr, output logic [31:0] data,
                             output logic [1:0] resp, output int lat);
        int  cyc;
        logic hs;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        cyc = 0;
        while (arvalid && cyc < 50) begin
            hs = arready;
            step();
            cyc++;
            if (hs) arvalid = 1'b0;
        end
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin
            step();
            lat++;
        end
        data = rdata;
        resp = rresp;
        step();
    endtask

    task automatic wr_check(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] resp;
        int lat;
        axil_write(addr, data, strb, resp, lat);
        check({tag, ".bresp"}, resp, exp_resp);
        check({tag, ".blat"}, 32'(lat), 0);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] data;
        logic [1:0]  resp;
        int lat;
        axil_read(addr, data, resp, lat);
        check({tag, ".rdata"}, data, exp_data);
        check({tag, ".rresp"}, resp, exp_resp);
        check({tag, ".rlat"}, 32'(lat), 0);
    endtask

    // Write to ch0 STATUS with a ch_err[0] pulse landing on the executing edge.
    task automatic w1c_with_err(input string tag, input logic [31:0] data);
        awaddr = 32'h104; awvalid = 1'b1; wdata = data; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b1; ch_err = 4'b0001;
        step();
        awvalid = 1'b0; wvalid = 1'b0; ch_err = 4'b0000;
        check({tag, ".bvalid"}, bvalid, 1);
        check({tag, ".bresp"}, bresp, 2'b00);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1;
        ch_busy = '0; ch_done = '0; ch_err = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst.awready", awready, 1);
        check("rst.wready", wready, 1);
        check("rst.arready", arready, 1);
        check("rst.bvalid", bvalid, 0);
        check("rst.rvalid", rvalid, 0);
        check("rst.rdata", rdata, 0);
        check("rst.irq", irq, 0);
        check("rst.ch_start", ch_start, 0);
        check("rst.ch_src", ch_src, 0);

        // Global page identity registers, including an unaligned address
        rd_check("rd.id", 32'h000, 32'hD3A0_0100, 2'b00);
        rd_check("rd.numch", 32'h00C, 32'd4, 2'b00);
        rd_check("rd.numch_unaligned", 32'h00E, 32'd4, 2'b00);

        // ch2 SRC with W presented two cycles ahead of AW
        wdata = 32'h1000_0000; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        step();
        wvalid = 1'b0;
        check("wfirst.wready_held", wready, 0);
        check("wfirst.no_bvalid", bvalid, 0);
        step();
        awaddr = 32'h148; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("wfirst.bvalid", bvalid, 1);
        check("wfirst.bresp", bresp, 2'b00);
        step();
        wr_check("wr.ch2_dst", 32'h14C, 32'h2000_0000, 4'hF, 2'b00);
        wr_check("wr.ch2_len", 32'h150, 32'h0000_0040, 4'hF, 2'b00);
        check("ch2.src_out", ch_src[95:64], 32'h1000_0000);
        check("ch2.dst_out", ch_dst[95:64], 32'h2000_0000);
        check("ch2.len_out", ch_len[71:48], 24'h000040);
        rd_check("rd.ch2_src", 32'h148, 32'h1000_0000, 2'b00);
        rd_check("rd.ch2_dst", 32'h14C, 32'h2000_0000, 2'b00);
        rd_check("rd.ch2_len", 32'h150, 32'h0000_0040, 2'b00);

        // Byte strobes on SCRATCH; LEN keeps only LEN_WIDTH bits
        wr_check("wr.scratch", 32'h008, 32'h1234_5678, 4'hF, 2'b00);
        wr_check("wr.scratch_strb", 32'h008, 32'hFFFF_FFFF, 4'b0101, 2'b00);
        rd_check("rd.scratch_strb", 32'h008, 32'h12FF_56FF, 2'b00);
        wr_check("wr.ch3_len", 32'h170, 32'hFFFF_FFFF, 4'hF, 2'b00);
        rd_check("rd.ch3_len", 32'h170, 32'h00FF_FFFF, 2'b00);

        // START + IRQ_EN on idle ch1
        wr_check("wr.ch1_ctrl", 32'h120, 32'h3, 4'hF, 2'b00);
        check("start1.count", 32'(start_cnt1), 1);
        check("start1.cleared", ch_start, 0);
        rd_check("rd.ch1_ctrl", 32'h120, 32'h2, 2'b00);

        // DONE event on ch1 raises irq one cycle later
        ch_done = 4'b0010;
        step();
        ch_done = 4'b0000;
        check("irq.lag", irq, 0);
        step();
        check("irq.set", irq, 1);
        rd_check("rd.ch1_status", 32'h124, 32'h2, 2'b00);
        rd_check("rd.irq_stat", 32'h004, 32'h2, 2'b00);
        wr_check("wr.ch1_w1c_done", 32'h124, 32'h2, 4'hF, 2'b00);
        check("irq.clear", irq, 0);
        rd_check("rd.ch1_status_clr", 32'h124, 32'h0, 2'b00);

        // START while busy drops; W1C against concurrent events
        ch_busy = 4'b0001;
        wr_check("wr.ch0_start_busy", 32'h100, 32'h1, 4'hF, 2'b00);
        check("start0.none", 32'(start_cnt0), 0);
        rd_check("rd.ch0_drop", 32'h104, 32'h9, 2'b00);
        w1c_with_err("w1c_drop_err", 32'h8);
        rd_check("rd.ch0_err_set", 32'h104, 32'h5, 2'b00);
        w1c_with_err("w1c_err_err", 32'h4);
        rd_check("rd.ch0_set_prio", 32'h104, 32'h5, 2'b00);
        wr_check("wr.ch0_w1c_err", 32'h104, 32'h4, 4'hF, 2'b00);
        rd_check("rd.ch0_busy_only", 32'h104, 32'h1, 2'b00);
        ch_busy = 4'b0000;
        rd_check("rd.ch0_idle", 32'h104, 32'h0, 2'b00);
        check("irq.ch0_disabled", irq, 0);

        // Decode errors
        wr_check("wr.bad_ch7", 32'h1E0, 32'hFFFF_FFFF, 4'hF, 2'b10);
        wr_check("wr.ro_id", 32'h000, 32'hFFFF_FFFF, 4'hF, 2'b10);
        wr_check("wr.ro_irqstat", 32'h004, 32'hFFFF_FFFF, 4'hF, 2'b10);
        check("decerr.ch_src", ch_src, {32'h0, 32'h1000_0000, 32'h0, 32'h0});
        check("decerr.ch_dst", ch_dst, {32'h0, 32'h2000_0000, 32'h0, 32'h0});
        check("decerr.ch_len", ch_len, {24'hFFFFFF, 24'h000040, 24'h0, 24'h0});
        rd_check("rd.id_after", 32'h000, 32'hD3A0_0100, 2'b00);
        rd_check("rd.scratch_after", 32'h008, 32'h12FF_56FF, 2'b00);
        rd_check("rd.bad_050", 32'h050, 32'h0, 2'b10);
        rd_check("rd.bad_200", 32'h200, 32'h0, 2'b10);
        rd_check("rd.bad_ch_reg", 32'h154, 32'h0, 2'b10);

        // Read and write of SCRATCH in the same cycle: read sees the old value
        araddr = 32'h008; arvalid = 1'b1; rready = 1'b1;
        awaddr = 32'h008; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b1;
        step();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        check("rw.rvalid", rvalid, 1);
        check("rw.old_data", rdata, 32'h12FF_56FF);
        check("rw.bvalid", bvalid, 1);
        step();
        rd_check("rd.scratch_new", 32'h008, 32'hCAFE_F00D, 2'b00);

        // B backpressure holds off further writes
        bready = 1'b0;
        awaddr = 32'h128; awvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp.bvalid", bvalid, 1);
            check("bp.awready", awready, 0);
            check("bp.wready", wready, 0);
            step();
        end
        bready = 1'b1;
        step();
        check("bp.bvalid_drop", bvalid, 0);
        check("bp.awready_back", awready, 1);
        check("bp.wready_back", wready, 1);
        check("bp.ch1_src", ch_src[63:32], 32'h5555_AAAA);

        // Reset in the middle of a held read response
        rready = 1'b0;
        araddr = 32'h008; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check("mid.rvalid", rvalid, 1);
        check("mid.rdata", rdata, 32'hCAFE_F00D);
        step();
        check("mid.rvalid_held", rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("mid.rvalid_rst", rvalid, 0);
        check("mid.rdata_rst", rdata, 0);
        check("mid.arready_rst", arready, 1);
        check("mid.ch_src_rst", ch_src, 0);
        step();
        rst_n = 1'b1;
        rready = 1'b1;
        step();
        rd_check("rd.post_scratch", 32'h008, 32'h0, 2'b00);
        rd_check("rd.post_ch2_src", 32'h148, 32'h0, 2'b00);
        rd_check("rd.post_ch3_len", 32'h170, 32'h0, 2'b00);
        rd_check("rd.post_ch1_ctrl", 32'h120, 32'h0, 2'b00);
        rd_check("rd.post_irq_stat", 32'h004, 32'h0, 2'b00);
        check("post.ch_dst", ch_dst, 0);
        check("post.ch_len", ch_len, 0);
        check("post.irq", irq, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
